// File: rtl/alu_pkg.sv
// Shared constants, command encodings and sequencer state for the ALU sequencer.
package alu_pkg;
  localparam int ALU_W = 16;

  localparam logic [2:0] ALU_ADD      = 3'd0;
  localparam logic [2:0] ALU_SUB      = 3'd1;
  localparam logic [2:0] ALU_AND      = 3'd2;
  localparam logic [2:0] ALU_MUL_HI   = 3'd3;
  localparam logic [2:0] ALU_MUL_LO   = 3'd4;
  localparam logic [2:0] ALU_DIV      = 3'd5;
  localparam logic [2:0] ALU_MOD      = 3'd6;
  localparam logic [2:0] ALU_MUL_FULL = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_EXEC_LO, S_EXEC_HI, S_RESP
  } seq_state_e;
endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response bundle between the instruction front-ends and the sequencer.
interface alu_sequencer_if #(parameter int W = 16, parameter int NREQ = 2);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][2:0]   req_cmd;
  logic [NREQ-1:0][W-1:0] req_a;
  logic [NREQ-1:0][W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_id;
  logic [W-1:0]           rsp_result;
  logic [W-1:0]           rsp_result_hi;
  logic                   rsp_zero;
  logic                   rsp_err;

  modport master (
    output req_valid, req_cmd, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_result_hi, rsp_zero, rsp_err
  );
  modport slave (
    input  req_valid, req_cmd, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_result_hi, rsp_zero, rsp_err
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; priority goes to the requester not granted last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  // last=1 means requester 1 was granted last, so requester 0 has priority
  logic last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = last ? 2'b01 : 2'b10;
      else      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end
endmodule

// File: rtl/alu_sequencer.sv
// Shares one combinational ALU between two requesters with two-pass MUL_FULL.
// Optional divide-by-zero bypass: define ALU_DIVZERO_CHECK_EN.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int W    = ALU_W,
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_sequencer_if.slave      bus,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [2:0]          alu_command,
  input  logic [W-1:0]        alu_result,
  input  logic                alu_zero,
  output logic [15:0]         ops_done
);
  seq_state_e      state, state_nx;
  logic [NREQ-1:0] gnt;
  logic            grant_en, acc, sel, divz, err_pend, hs;
  logic [2:0]      cmd_sel;
  logic [W-1:0]    a_sel, b_sel;

  assign grant_en = (state == S_IDLE) && rst_n;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (grant_en),
    .req   (bus.req_valid),
    .gnt   (gnt)
  );

  assign bus.req_ready = gnt;
  assign acc     = |gnt;
  assign sel     = gnt[1];
  assign cmd_sel = bus.req_cmd[sel];
  assign a_sel   = bus.req_a[sel];
  assign b_sel   = bus.req_b[sel];
  assign hs      = bus.rsp_valid && bus.rsp_ready;

`ifdef ALU_DIVZERO_CHECK_EN
  logic err_q;
  assign divz = ((cmd_sel == ALU_DIV) || (cmd_sel == ALU_MOD)) && (b_sel == '0);

  // err_pend delays rsp_valid one cycle so the bypass matches the EXEC latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      err_pend <= 1'b0;
    end else if (state == S_IDLE && acc) begin
      err_q    <= divz;
      err_pend <= divz;
    end else begin
      err_pend <= 1'b0;
    end
  end
  assign bus.rsp_err = err_q;
`else
  assign divz        = 1'b0;
  assign err_pend    = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (acc) begin
        if (divz)                         state_nx = S_RESP;
        else if (cmd_sel == ALU_MUL_FULL) state_nx = S_EXEC_LO;
        else                              state_nx = S_EXEC;
      end
      S_EXEC:    state_nx = S_RESP;
      S_EXEC_LO: state_nx = S_EXEC_HI;
      S_EXEC_HI: state_nx = S_RESP;
      S_RESP:    if (hs) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a             <= '0;
      alu_b             <= '0;
      alu_command       <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_id        <= 1'b0;
      bus.rsp_result    <= '0;
      bus.rsp_result_hi <= '0;
      bus.rsp_zero      <= 1'b0;
      ops_done          <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (acc) begin
          bus.rsp_id <= sel;
          if (divz) begin
            bus.rsp_result    <= {W{1'b1}};
            bus.rsp_result_hi <= '0;
            bus.rsp_zero      <= 1'b0;
          end else begin
            alu_a       <= a_sel;
            alu_b       <= b_sel;
            alu_command <= (cmd_sel == ALU_MUL_FULL) ? ALU_MUL_LO : cmd_sel;
          end
        end
        S_EXEC: begin
          bus.rsp_result    <= alu_result;
          bus.rsp_result_hi <= '0;
          bus.rsp_zero      <= alu_zero;
          bus.rsp_valid     <= 1'b1;
        end
        S_EXEC_LO: begin
          bus.rsp_result <= alu_result;
          alu_command    <= ALU_MUL_HI;
        end
        S_EXEC_HI: begin
          bus.rsp_result_hi <= alu_result;
          bus.rsp_zero      <= alu_zero;
          bus.rsp_valid     <= 1'b1;
        end
        S_RESP: begin
          if (err_pend) begin
            bus.rsp_valid <= 1'b1;
          end else if (hs) begin
            bus.rsp_valid <= 1'b0;
            ops_done      <= ops_done + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
